sha256_multiblock: RTL
======================

SHA256_MULTIBLOCK -- requirements
Module: sha256_multiblock

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, giving the message length in 32-bit words; legal range 1..1024.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  begin a hash; sampled in IDLE or DONE only.
REQ-005 SHALL have port message_addr  input  16  word address of message word 0; captured when start is accepted.
REQ-006 SHALL have port output_addr  input  16  word address for H0; H1..H7 go to consecutive addresses; captured when start is accepted.
REQ-007 SHALL have port done  output  1  hash written; held high until the next accepted start.
REQ-008 SHALL have port mem_clk  output  1  equal to clk.
REQ-009 SHALL have port mem_we  output  1  write strobe, one word per cycle.
REQ-010 SHALL have port mem_addr  output  16  memory word address.
REQ-011 SHALL have port mem_write_data  output  32  write data.
REQ-012 SHALL have port mem_read_data  input  32  read data; valid for sampling on the second rising clk after mem_addr is driven.

Function
REQ-013 SHALL compute the FIPS 180-4 SHA-256 digest of NUM_OF_WORDS words stored big-endian-per-word at message_addr.
REQ-014 SHALL process NB = floor((NUM_OF_WORDS+18)/16) blocks of 16 words each, indexed by global word index i.
REQ-015 SHALL source word i as follows: i<NUM_OF_WORDS from memory; i=NUM_OF_WORDS gives 0x80000000; i=16*NB-1 gives NUM_OF_WORDS*32; all other words give 0. Padding words SHALL NOT be fetched from memory.
REQ-016 SHALL use the state machine IDLE -> READ -> COMPUTE -> UPDATE -> (READ if blocks remain, else WRITE) -> DONE -> (READ on start).
REQ-017 READ SHALL issue one read address per cycle, pipelined, and fill a 16-entry word buffer within 18 cycles.
REQ-018 COMPUTE SHALL perform exactly one round per cycle for t=0..63, generating W[t] for t>=16 on the fly from a 16-word shift register.
REQ-019 UPDATE SHALL add a..h into H0..H7 modulo 2^32 in one cycle; H SHALL start at the standard IV (0x6a09e667 .. 0x5be0cd19) for block 0.
REQ-020 WRITE SHALL assert mem_we for exactly 8 consecutive cycles, writing H0..H7 to output_addr+0..7; mem_we SHALL be 0 in all other states.
REQ-021 done SHALL rise the cycle after the final write; total start-to-done latency SHALL be at most 86*NB+12 cycles.
REQ-022 A start held for multiple cycles SHALL produce exactly one hash; start outside IDLE/DONE SHALL be ignored.
REQ-023 All address arithmetic SHALL wrap modulo 2^16.

Reset
REQ-024 When reset_n=0, the block SHALL enter IDLE with done=0, mem_we=0, mem_addr=0, mem_write_data=0, and all counters cleared, at any state including mid-operation.
REQ-025 After a mid-operation reset, the block SHALL perform no memory write until a new start is accepted.

Configuration
REQ-026 With macro SHA256_CYCLE_COUNT_EN defined, the block SHALL add output port cycle_count (32 bits), cleared on accepted start, incremented every cycle until done rises, then frozen. It SHALL be reset to 0.
REQ-027 Without SHA256_CYCLE_COUNT_EN, port cycle_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 NUM_OF_WORDS=20, seed 0x01234765, word k = rotl1(word k-1), word 19 = 0, output_addr=1000 -> 2 blocks; memory 1000..1007 matches the software SHA-256 model; done=1.
REQ-029 NUM_OF_WORDS=13 -> NB=1; word 13 = 0x80000000, word 15 = 416; digest matches the model; latency <= 98 cycles.
REQ-030 NUM_OF_WORDS=14 -> NB=2; second block is padding only (word 15 = 448); digest matches; exactly 8 mem_we cycles in total.
REQ-031 start held 5 cycles, then a second start pulse mid-COMPUTE -> a single hash; second pulse ignored; writes occur only once.
REQ-032 reset_n=0 for 1 cycle during COMPUTE of block 0 -> no writes; done=0; a new start then yields the correct digest.
REQ-033 With SHA256_CYCLE_COUNT_EN, NUM_OF_WORDS=20 -> cycle_count equals the number of cycles from start acceptance to done, and is <= 184.

Source files
------------

// File: rtl/sha256_multiblock.sv
// sha256_multiblock
//   FIPS 180-4 SHA-256 over a fixed-length message of NUM_OF_WORDS 32-bit
//   words held in an external word-addressed memory.
//   Padding words are generated internally and are never fetched.
//   The 8-word digest is written back starting at output_addr.
//
// Ports
//   clk            system clock
//   reset_n        synchronous active-low reset
//   start          begin a hash (accepted only in IDLE or DONE)
//   message_addr   word address of message word 0 (captured on start)
//   output_addr    word address for H0, H1..H7 follow (captured on start)
//   done           digest written, held until the next accepted start
//   mem_clk        memory clock, equal to clk
//   mem_we         memory write strobe
//   mem_addr       memory word address
//   mem_write_data memory write data
//   mem_read_data  memory read data, sampled two rising edges after the address
//   cycle_count    (only with SHA256_CYCLE_COUNT_EN) cycles from start to done
//
// Configuration macro
//   SHA256_CYCLE_COUNT_EN  adds the cycle_count output and its counter

module sha256_multiblock #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
`ifdef SHA256_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_count
`endif
);

    localparam int          NB         = (NUM_OF_WORDS + 18) / 16;
    localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST_WORD  = 16'(16 * NB - 1);
    localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);
    localparam logic [6:0]  LAST_BLOCK = 7'(NB - 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE,
        READ,
        COMPUTE,
        UPDATE,
        WRITE,
        DONE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state;
    state_t      state_next;
    logic        start_accept;
    logic [6:0]  cnt;
    logic [6:0]  blk;
    logic [15:0] msg_base;
    logic [15:0] out_base;
    logic [15:0] rd_addr;
    logic [31:0] h_reg [8];
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] sum [8];
    logic [15:0] issue_idx;
    logic [15:0] fill_idx;
    logic [3:0]  fill_slot;
    logic [31:0] fill_word;
    logic [31:0] w_new;
    logic [31:0] t1;
    logic [31:0] t2;

    assign mem_clk = clk;

    // State register; reset forces IDLE from any state so an interrupted
    // hash can never reach WRITE without a fresh start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the memory-facing outputs. Outside WRITE the
    // address bus shows the registered read address so the memory sees a
    // stable address for its two-edge read latency.
    always_comb begin
        state_next     = state;
        start_accept   = 1'b0;
        done           = (state == DONE);
        mem_we         = 1'b0;
        mem_addr       = rd_addr;
        mem_write_data = 32'd0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = READ;
                    start_accept = 1'b1;
                end
            end
            READ: begin
                if (cnt == 7'd17) state_next = COMPUTE;
            end
            COMPUTE: begin
                if (cnt == 7'd63) state_next = UPDATE;
            end
            UPDATE: begin
                state_next = (blk == LAST_BLOCK) ? WRITE : READ;
            end
            WRITE: begin
                mem_we         = 1'b1;
                mem_addr       = out_base + {13'd0, cnt[2:0]};
                mem_write_data = h_reg[cnt[2:0]];
                if (cnt == 7'd7) state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Step counter shared by READ, COMPUTE and WRITE; it restarts at every
    // state change so each phase sees 0 on its first cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= 7'd0;
        end else if (state_next != state) begin
            cnt <= 7'd0;
        end else if (state == READ || state == COMPUTE || state == WRITE) begin
            cnt <= cnt + 7'd1;
        end
    end

    // Block index and the addresses captured when a start is taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blk      <= 7'd0;
            msg_base <= 16'd0;
            out_base <= 16'd0;
        end else if (start_accept) begin
            blk      <= 7'd0;
            msg_base <= message_addr;
            out_base <= output_addr;
        end else if (state == UPDATE) begin
            blk <= blk + 7'd1;
        end
    end

    // Word indices: addresses go out on READ steps 0..15, and the matching
    // data comes back two steps later, landing in buffer slot cnt-2.
    always_comb begin
        issue_idx = {5'd0, blk, 4'd0} + {12'd0, cnt[3:0]};
        fill_slot = 4'(cnt - 7'd2);
        fill_idx  = {5'd0, blk, 4'd0} + {12'd0, fill_slot};
        if (fill_idx < MSG_WORDS) begin
            fill_word = mem_read_data;
        end else if (fill_idx == MSG_WORDS) begin
            fill_word = 32'h80000000;
        end else if (fill_idx == LAST_WORD) begin
            fill_word = BIT_LEN;
        end else begin
            fill_word = 32'd0;
        end
    end

    // Read address register. Only real message words are requested, so
    // padding positions leave the bus parked on the last fetched address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_addr <= 16'd0;
        end else if (state == READ && cnt < 7'd16 && issue_idx < MSG_WORDS) begin
            rd_addr <= msg_base + issue_idx;
        end
    end

    // Message schedule: w[0] is always W[t]; each round shifts down one and
    // appends W[t+16], which depends only on words already in the window.
    always_comb begin
        w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10))
              + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3))
              + w[0];
    end

    // Word buffer: filled by slot during READ, shifted once per round.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) w[i] <= 32'd0;
        end else if (state == READ && cnt >= 7'd2) begin
            w[fill_slot] <= fill_word;
        end else if (state == COMPUTE) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= w_new;
        end
    end

    // Round function terms and the block-end chaining sums.
    always_comb begin
        t1 = h
           + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
           + ((e & f) ^ (~e & g))
           + K[cnt[5:0]]
           + w[0];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
        sum[0] = h_reg[0] + a;
        sum[1] = h_reg[1] + b;
        sum[2] = h_reg[2] + c;
        sum[3] = h_reg[3] + d;
        sum[4] = h_reg[4] + e;
        sum[5] = h_reg[5] + f;
        sum[6] = h_reg[6] + g;
        sum[7] = h_reg[7] + h;
    end

    // Working variables and hash state. UPDATE loads a..h with the new H as
    // well, so the next block starts from the chained value without an
    // extra load cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= 32'd0;
            {a, b, c, d, e, f, g, h} <= '0;
        end else if (start_accept) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
            {a, b, c, d, e, f, g, h} <= {IV[0], IV[1], IV[2], IV[3],
                                         IV[4], IV[5], IV[6], IV[7]};
        end else if (state == COMPUTE) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
        end else if (state == UPDATE) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= sum[i];
            {a, b, c, d, e, f, g, h} <= {sum[0], sum[1], sum[2], sum[3],
                                         sum[4], sum[5], sum[6], sum[7]};
        end
    end

`ifdef SHA256_CYCLE_COUNT_EN
    // Counts every cycle spent between an accepted start and done; it stops
    // on its own because DONE is excluded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_count <= 32'd0;
        end else if (start_accept) begin
            cycle_count <= 32'd0;
        end else if (state != IDLE && state != DONE) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
